// File: rtl/rev_gates_pkg.sv
// Shared definitions for the double Feynman gate path: the triple type
// and the reference encode/decode functions used by encoder, decoder and bench.
package rev_gates_pkg;

   localparam int DFG_WIDTH = 8;

   // One lane-wise triple. For the encoder output the fields hold (p,q,r).
   typedef struct packed {
      logic [DFG_WIDTH-1:0] a;
      logic [DFG_WIDTH-1:0] b;
      logic [DFG_WIDTH-1:0] c;
   } triple_t;

   // Double Feynman gate: (a,b,c) -> (a, a^b, a^c), returned in fields a,b,c.
   function automatic triple_t dfg_encode(input logic [DFG_WIDTH-1:0] a,
                                          input logic [DFG_WIDTH-1:0] b,
                                          input logic [DFG_WIDTH-1:0] c);
      triple_t t;
      t.a = a;
      t.b = a ^ b;
      t.c = a ^ c;
      return t;
   endfunction

   // Inverse gate: (p,q,r) -> (p, q^p, r^p).
   function automatic triple_t dfg_decode(input logic [DFG_WIDTH-1:0] p,
                                          input logic [DFG_WIDTH-1:0] q,
                                          input logic [DFG_WIDTH-1:0] r);
      triple_t t;
      t.a = p;
      t.b = q ^ p;
      t.c = r ^ p;
      return t;
   endfunction

endpackage

// File: rtl/double_feynman_decoder_if.sv
// Valid/ready bus for the decoder: encoded triples in, decoded triples out.
interface double_feynman_decoder_if
   import rev_gates_pkg::*;
   #(parameter int WIDTH = DFG_WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_p;
   logic [WIDTH-1:0] in_q;
   logic [WIDTH-1:0] in_r;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [WIDTH-1:0] out_c;

   modport master (
      output in_valid, in_p, in_q, in_r, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_c
   );

   modport slave (
      input  in_valid, in_p, in_q, in_r, out_ready,
      output in_ready, out_valid, out_a, out_b, out_c
   );

endinterface

// File: rtl/dfg_stream_fifo.sv
// Generic DEPTH x DATA_W FIFO with a registered head word.
// The head register keeps the last popped word once the FIFO drains.
module dfg_stream_fifo #(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        push_data,
   output logic [DATA_W-1:0]        head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LEVEL_W = PTR_W + 1;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_next, rd_next;
   logic [LEVEL_W-1:0] level_q, level_next;
   logic [DATA_W-1:0]  head_q;

   assign full  = (level_q == LEVEL_W'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign head  = head_q;

   // Next pointers and occupancy; flush wins over any push or pop.
   always_comb begin
      wr_next    = wr_ptr;
      rd_next    = rd_ptr;
      level_next = level_q;
      if (flush) begin
         wr_next    = '0;
         rd_next    = '0;
         level_next = '0;
      end else begin
         if (push) wr_next = wr_ptr + PTR_W'(1);
         if (pop)  rd_next = rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_next = level_q + LEVEL_W'(1);
            2'b01:   level_next = level_q - LEVEL_W'(1);
            default: level_next = level_q;
         endcase
      end
   end

   // Storage array is written without reset; only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         wr_ptr  <= wr_next;
         rd_ptr  <= rd_next;
         level_q <= level_next;
      end
   end

   // Head register loads the next oldest word, taking the incoming word when it lands in the head slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
      end else if (!flush && level_next != '0) begin
         head_q <= (push && wr_ptr == rd_next) ? push_data : mem[rd_next];
      end
   end

endmodule

// File: rtl/double_feynman_decoder.sv
// Streaming double Feynman decoder: XOR decode on entry, FIFO buffering,
// valid/ready glue and a wrapping delivered-word counter.
module double_feynman_decoder
   import rev_gates_pkg::*;
   #(
   parameter int WIDTH   = DFG_WIDTH,
   parameter int DEPTH   = 4,
   parameter int COUNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   double_feynman_decoder_if.slave bus,
   output logic [$clog2(DEPTH):0] level,
   output logic [COUNT_W-1:0]     count
);

   logic                 full, empty, push, pop;
   logic [3*WIDTH-1:0]   decoded, head;

   assign decoded = {bus.in_p, bus.in_q ^ bus.in_p, bus.in_r ^ bus.in_p};

   assign bus.in_ready  = !full && !flush;
   assign bus.out_valid = !empty;
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   assign bus.out_a = head[3*WIDTH-1 -: WIDTH];
   assign bus.out_b = head[2*WIDTH-1 -: WIDTH];
   assign bus.out_c = head[WIDTH-1   -: WIDTH];

   dfg_stream_fifo #(
      .DATA_W (3*WIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .pop       (pop),
      .push_data (decoded),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   // Delivered-word counter; a pop coinciding with flush is not a delivery.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (pop && !flush) begin
         count <= count + COUNT_W'(1);
      end
   end

endmodule
